// File: rtl/servo_pkg.sv
// Shared definitions for the servo front-end: receiver FSM encoding and frame geometry.
package servo_pkg;

  localparam int LEAD_BITS_DEF = 4;
  localparam int DATA_W_DEF    = 12;
  localparam int FRAME_BITS    = LEAD_BITS_DEF + DATA_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LOAD,
    HOLD,
    QUIET
  } state_t;

endpackage

// File: rtl/sclk_divider.sv
// Free-running ADC serial clock generator: sclk period is 2*CLK_DIV clk cycles.
// rise_tick/fall_tick flag the clk cycle whose closing edge makes sclk rise or fall.
module sclk_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          term;

  assign term      = (cnt == TERM);
  assign rise_tick = term & ~sclk;
  assign fall_tick = term &  sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (term) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_serial_rx.sv
// Serial front-end for the 12-bit SPI-style servo ADC: drives CS/sample clock, shifts in
// 16-bit frames and strobes each sample out. Define ADC_ZERO_CHECK_EN to flag nonzero lead bits.
module adc_serial_rx
  import servo_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int LEAD_BITS    = LEAD_BITS_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int QUIET_CYCLES = 18
) (
  input  logic                 Clock_Nexys,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 data_ADC,
  output logic                 CS,
  output logic                 Clock_Muestreo,
  output logic [LEAD_BITS-1:0] data_basura,
  output logic [DATA_W-1:0]    dato_adc,
  output logic                 dato_valido,
  output logic                 error_cero
);

  localparam int FW = LEAD_BITS + DATA_W;
  localparam int BW = $clog2(FW + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(FW - 1);
  localparam logic [QW-1:0] LAST_QUIET = QW'(QUIET_CYCLES - 1);

  logic          rise_tick;
  logic          fall_tick;
  state_t        state;
  logic [FW-2:0] sr;
  logic [FW-1:0] sr_next;
  logic [BW-1:0] bit_cnt;
  logic [QW-1:0] quiet_cnt;
  logic          load_now;

  sclk_divider #(.CLK_DIV(CLK_DIV)) u_sclk_divider (
    .clk       (Clock_Nexys),
    .rst       (Reset),
    .sclk      (Clock_Muestreo),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // The last bit is taken straight from data_ADC so the word and its strobe land in the LOAD cycle.
  assign sr_next  = {sr, data_ADC};
  assign load_now = (state == SHIFT) && rise_tick && (bit_cnt == LAST_BIT);

  always_ff @(posedge Clock_Nexys or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      CS          <= 1'b1;
      sr          <= '0;
      bit_cnt     <= '0;
      quiet_cnt   <= '0;
      dato_adc    <= '0;
      data_basura <= '0;
      dato_valido <= 1'b0;
    end else begin
      // NOTE: default-low assignment ahead of the case makes dato_valido a one-cycle strobe.
      dato_valido <= 1'b0;
      case (state)
        IDLE: begin
          CS <= 1'b1;
          if (fall_tick && start) begin
            CS      <= 1'b0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise_tick) begin
            sr      <= sr_next[FW-2:0];
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (load_now) begin
            dato_adc    <= sr_next[DATA_W-1:0];
            data_basura <= sr_next[FW-1:DATA_W];
            dato_valido <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: state <= HOLD;
        HOLD: begin
          if (fall_tick) begin
            CS        <= 1'b1;
            quiet_cnt <= '0;
            state     <= QUIET;
          end
        end
        QUIET: begin
          if (fall_tick) begin
            if (quiet_cnt == LAST_QUIET) state <= IDLE;
            else                         quiet_cnt <= quiet_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_ZERO_CHECK_EN
  logic error_q;

  always_ff @(posedge Clock_Nexys or posedge Reset) begin
    if (Reset)         error_q <= 1'b0;
    else if (load_now) error_q <= |sr_next[FW-1:DATA_W];
  end

  assign error_cero = error_q;
`else
  assign error_cero = 1'b0;
`endif

endmodule

// File: tb/tb_adc_serial_rx.sv
// Directed self-checking bench for adc_serial_rx with a behavioural ADC driving data_ADC.
module tb_adc_serial_rx;
  import servo_pkg::*;

  logic        Clock_Nexys = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        data_ADC = 1'b0;
  logic        CS;
  logic        Clock_Muestreo;
  logic [3:0]  data_basura;
  logic [11:0] dato_adc;
  logic        dato_valido;
  logic        error_cero;

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] tx_word = 16'h0000;

`ifdef ADC_ZERO_CHECK_EN
  localparam logic ZC_EXP = 1'b1;
`else
  localparam logic ZC_EXP = 1'b0;
`endif

  adc_serial_rx #(.CLK_DIV(2), .LEAD_BITS(4), .DATA_W(12), .QUIET_CYCLES(18)) dut (
    .Clock_Nexys    (Clock_Nexys),
    .Reset          (Reset),
    .start          (start),
    .data_ADC       (data_ADC),
    .CS             (CS),
    .Clock_Muestreo (Clock_Muestreo),
    .data_basura    (data_basura),
    .dato_adc       (dato_adc),
    .dato_valido    (dato_valido),
    .error_cero     (error_cero)
  );

  always #5 Clock_Nexys = ~Clock_Nexys;

  // ADC model: MSB presented while CS is high, next bit after each falling sample clock.
  initial begin : adc_model
    int r;
    logic prev;
    logic [15:0] w;
    r = 0;
    prev = 1'b0;
    forever begin
      @(negedge Clock_Nexys);
      w = tx_word;
      if (CS) begin
        r = 0;
        data_ADC = w[15];
      end else if (Clock_Muestreo && !prev) begin
        r++;
      end else if (!Clock_Muestreo && prev) begin
        data_ADC = (r < FRAME_BITS) ? w[15 - r] : 1'b0;
      end
      prev = Clock_Muestreo;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge Clock_Nexys);
  endtask

  task automatic settle();
    repeat (120) tick();
  endtask

  // Requests one frame and observes it until CS returns high.
  task automatic capture_frame(input bit hold, output int cs_low, output int pulses,
                               output logic [11:0] d, output logic [3:0] lb, output logic e,
                               output bit lat_ok, output bit timed_out);
    logic prev, rise;
    bit seen;
    int rises;
    cs_low = 0; pulses = 0; d = '0; lb = '0; e = 1'b0; lat_ok = 0;
    seen = 0; rises = 0;
    prev = Clock_Muestreo;
    start = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (!hold && i == 4) start = 1'b0;
      rise = Clock_Muestreo && !prev;
      prev = Clock_Muestreo;
      if (!CS) begin
        seen = 1;
        cs_low++;
        if (rise) rises++;
      end
      if (dato_valido) begin
        pulses++;
        d = dato_adc; lb = data_basura; e = error_cero;
        lat_ok = rise && (rises == 16);
      end
      if (seen && CS) break;
    end
    timed_out = !(seen && CS);
    start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    tests_run++; if (CS !== 1'b1) begin tests_failed++; $display("FAIL reset_cs: got %b want 1", CS); end
    tests_run++; if (Clock_Muestreo !== 1'b0) begin tests_failed++; $display("FAIL reset_sclk: got %b want 0", Clock_Muestreo); end
    tests_run++; if (dato_adc !== 12'h000) begin tests_failed++; $display("FAIL reset_dato: got %h want 000", dato_adc); end
    tests_run++; if (data_basura !== 4'h0) begin tests_failed++; $display("FAIL reset_basura: got %h want 0", data_basura); end
    tests_run++; if (dato_valido !== 1'b0) begin tests_failed++; $display("FAIL reset_valido: got %b want 0", dato_valido); end
    tests_run++; if (error_cero !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b want 0", error_cero); end
    Reset = 1'b0;
  endtask

  task automatic test_divider();
    int highs, rises, bad_gap, last, cs_bad, vld;
    logic prev;
    bit found;
    start = 1'b0;
    found = 0;
    prev = Clock_Muestreo;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (Clock_Muestreo && !prev) found = 1;
      prev = Clock_Muestreo;
    end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL div_align: got %b want 1", found); end
    highs = 0; rises = 0; bad_gap = 0; last = 0; cs_bad = 0; vld = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (Clock_Muestreo) highs++;
      if (Clock_Muestreo && !prev) begin
        rises++;
        if (i - last != 4) bad_gap++;
        last = i;
      end
      prev = Clock_Muestreo;
      if (CS !== 1'b1) cs_bad++;
      if (dato_valido !== 1'b0) vld++;
    end
    tests_run++; if (rises != 100) begin tests_failed++; $display("FAIL div_rises: got %0d want 100", rises); end
    tests_run++; if (bad_gap != 0) begin tests_failed++; $display("FAIL div_period: got %0d bad gaps want 0", bad_gap); end
    tests_run++; if (highs != 200) begin tests_failed++; $display("FAIL div_duty: got %0d high cycles want 200", highs); end
    tests_run++; if (cs_bad != 0) begin tests_failed++; $display("FAIL div_cs_idle: got %0d low cycles want 0", cs_bad); end
    tests_run++; if (vld != 0) begin tests_failed++; $display("FAIL div_valido: got %0d strobes want 0", vld); end
  endtask

  task automatic test_single_frame();
    int cs_low, pulses;
    logic [11:0] d;
    logic [3:0] lb;
    logic e;
    bit lat_ok, to;
    settle();
    tx_word = 16'h0A5C;
    capture_frame(0, cs_low, pulses, d, lb, e, lat_ok, to);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL single_timeout: got %b want 0", to); end
    tests_run++; if (cs_low != 64) begin tests_failed++; $display("FAIL single_cs_low: got %0d want 64", cs_low); end
    tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    tests_run++; if (d !== 12'hA5C) begin tests_failed++; $display("FAIL single_dato: got %h want a5c", d); end
    tests_run++; if (lb !== 4'h0) begin tests_failed++; $display("FAIL single_basura: got %h want 0", lb); end
    tests_run++; if (lat_ok !== 1'b1) begin tests_failed++; $display("FAIL single_latency: got %b want 1", lat_ok); end
    repeat (20) tick();
    tests_run++; if (dato_adc !== 12'hA5C) begin tests_failed++; $display("FAIL single_hold: got %h want a5c", dato_adc); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] words [3];
    int strobe_at [3];
    int k, n;
    words[0] = 12'h000; words[1] = 12'hFFF; words[2] = 12'h801;
    settle();
    tx_word = {4'h0, words[0]};
    start = 1'b1;
    k = 0; n = 0;
    for (int i = 0; i < 700 && k < 3; i++) begin
      tick();
      n++;
      if (dato_valido) begin
        tests_run++; if (dato_adc !== words[k]) begin tests_failed++; $display("FAIL b2b_dato%0d: got %h want %h", k, dato_adc, words[k]); end
        strobe_at[k] = n;
        k++;
        if (k < 3) tx_word = {4'h0, words[k]};
        else       start = 1'b0;
      end
    end
    start = 1'b0;
    tests_run++; if (k != 3) begin tests_failed++; $display("FAIL b2b_count: got %0d strobes want 3", k); end
    if (k == 3) begin
      tests_run++; if (strobe_at[1] - strobe_at[0] != 140) begin tests_failed++; $display("FAIL b2b_gap1: got %0d want 140", strobe_at[1] - strobe_at[0]); end
      tests_run++; if (strobe_at[2] - strobe_at[1] != 140) begin tests_failed++; $display("FAIL b2b_gap2: got %0d want 140", strobe_at[2] - strobe_at[1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int rises, vld, cs_low, pulses;
    logic prev;
    logic [11:0] d;
    logic [3:0] lb;
    logic e;
    bit lat_ok, to;
    settle();
    tx_word = 16'h0FFF;
    start = 1'b1;
    rises = 0; vld = 0;
    prev = Clock_Muestreo;
    for (int i = 1; i <= 200 && rises < 7; i++) begin
      tick();
      if (i == 4) start = 1'b0;
      if (!CS && Clock_Muestreo && !prev) rises++;
      prev = Clock_Muestreo;
      if (dato_valido) vld++;
    end
    start = 1'b0;
    tests_run++; if (rises != 7) begin tests_failed++; $display("FAIL rst_mid_reach: got %0d rises want 7", rises); end
    Reset = 1'b1;
    #1;
    tests_run++; if (CS !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_cs: got %b want 1", CS); end
    tests_run++; if (Clock_Muestreo !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_sclk: got %b want 0", Clock_Muestreo); end
    repeat (3) begin
      tick();
      if (dato_valido) vld++;
    end
    tests_run++; if (vld != 0) begin tests_failed++; $display("FAIL rst_mid_valido: got %0d strobes want 0", vld); end
    tests_run++; if (dato_adc !== 12'h000) begin tests_failed++; $display("FAIL rst_mid_dato: got %h want 000", dato_adc); end
    Reset = 1'b0;
    tx_word = 16'h0123;
    capture_frame(0, cs_low, pulses, d, lb, e, lat_ok, to);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL rst_after_timeout: got %b want 0", to); end
    tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL rst_after_pulses: got %0d want 1", pulses); end
    tests_run++; if (d !== 12'h123) begin tests_failed++; $display("FAIL rst_after_dato: got %h want 123", d); end
  endtask

  task automatic test_start_in_quiet();
    int cs_low, pulses, low, vld;
    logic [11:0] d;
    logic [3:0] lb;
    logic e;
    bit lat_ok, to;
    settle();
    tx_word = 16'h0555;
    capture_frame(0, cs_low, pulses, d, lb, e, lat_ok, to);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL quiet_frame_timeout: got %b want 0", to); end
    tests_run++; if (d !== 12'h555) begin tests_failed++; $display("FAIL quiet_frame_dato: got %h want 555", d); end
    repeat (20) tick();
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    low = 0; vld = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!CS) low++;
      if (dato_valido) vld++;
    end
    tests_run++; if (low != 0) begin tests_failed++; $display("FAIL quiet_cs: got %0d low cycles want 0", low); end
    tests_run++; if (vld != 0) begin tests_failed++; $display("FAIL quiet_valido: got %0d strobes want 0", vld); end
    tests_run++; if (CS !== 1'b1) begin tests_failed++; $display("FAIL quiet_idle_cs: got %b want 1", CS); end
  endtask

  task automatic test_zero_check();
    int cs_low, pulses;
    logic [11:0] d;
    logic [3:0] lb;
    logic e;
    bit lat_ok, to;
    settle();
    tx_word = 16'h43C3;
    capture_frame(0, cs_low, pulses, d, lb, e, lat_ok, to);
    tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL zc_pulses: got %0d want 1", pulses); end
    tests_run++; if (d !== 12'h3C3) begin tests_failed++; $display("FAIL zc_dato: got %h want 3c3", d); end
    tests_run++; if (lb !== 4'h4) begin tests_failed++; $display("FAIL zc_basura: got %h want 4", lb); end
    tests_run++; if (e !== ZC_EXP) begin tests_failed++; $display("FAIL zc_error_set: got %b want %b", e, ZC_EXP); end
    repeat (50) tick();
    tests_run++; if (error_cero !== ZC_EXP) begin tests_failed++; $display("FAIL zc_error_sticky: got %b want %b", error_cero, ZC_EXP); end
    settle();
    tx_word = 16'h0ABC;
    capture_frame(0, cs_low, pulses, d, lb, e, lat_ok, to);
    tests_run++; if (d !== 12'hABC) begin tests_failed++; $display("FAIL zc_clean_dato: got %h want abc", d); end
    tests_run++; if (lb !== 4'h0) begin tests_failed++; $display("FAIL zc_clean_basura: got %h want 0", lb); end
    tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL zc_error_clear: got %b want 0", e); end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_start_in_quiet();
    test_zero_check();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/adc_serial_rx.md
Name: adc_serial_rx

Overview:
Serial front-end for the 12-bit SPI-style ADC that feeds the servo loop.
- Generates the free-running sample clock Clock_Muestreo and the chip select CS.
- Shifts in a 16-bit frame (4 leading zeros plus 12 data bits, MSB first) and presents the word to the downstream PID stage with a one-cycle valid strobe.
- Sits directly upstream of the controller inside Servo_Top.

Parameters:
CLK_DIV, 2, Clock_Nexys cycles per Clock_Muestreo half-period (>=1); Clock_Muestreo period = 2*CLK_DIV
LEAD_BITS, 4, leading zero bits per frame
DATA_W, 12, data bits per frame
QUIET_CYCLES, 18, Clock_Muestreo periods CS stays high after a frame (>=1)

Ports:
Clock_Nexys  in  1  system clock; the only clock
Reset  in  1  asynchronous, active-high reset
start  in  1  conversion request; level, sampled only in IDLE
data_ADC  in  1  serial data from the ADC, driven by the ADC on Clock_Muestreo falling edges
CS  out  1  chip select, active low
Clock_Muestreo  out  1  ADC serial clock, free-running
data_basura  out  LEAD_BITS  leading bits of the last frame
dato_adc  out  DATA_W  last received sample
dato_valido  out  1  one-Clock_Nexys-cycle strobe when dato_adc updates
error_cero  out  1  leading-bit error flag (see Optional Feature)

Behaviour:
- Reset values: Clock_Muestreo=0, CS=1, dato_adc=0, data_basura=0, dato_valido=0, error_cero=0; all counters 0; FSM in IDLE. Reset asserted mid-frame aborts the frame with no valid strobe.
- Divider: counter 0..CLK_DIV-1 in Clock_Nexys cycles; Clock_Muestreo toggles at terminal count.
  - Internal rise_tick/fall_tick are high for the single Clock_Nexys cycle in which Clock_Muestreo goes 0->1 or 1->0.
  - The divider runs regardless of FSM state.
- All register updates occur in the same Clock_Nexys cycle as the qualifying tick. data_ADC is sampled on rise_tick.
- FSM:
  - IDLE: CS=1. On fall_tick with start=1: CS<=0, bit counter<=0, go to SHIFT. start=0 keeps the FSM in IDLE indefinitely.
  - SHIFT: on each rise_tick, shift data_ADC into a 16-bit shift register (MSB first) and increment the bit counter. On the 16th rise_tick, go to LOAD.
  - LOAD: one Clock_Nexys cycle.
    - dato_adc <= sr[DATA_W-1:0]; data_basura <= sr[15:DATA_W].
    - dato_valido=1 for exactly this cycle.
    - Go to HOLD.
  - HOLD: CS stays 0 until the next fall_tick, then CS<=1, quiet counter<=0, go to QUIET.
  - QUIET: CS=1; count fall_ticks. When the count reaches QUIET_CYCLES, go to IDLE. A start pulse during QUIET is ignored (not queued).
- Latency: dato_valido rises 1 Clock_Nexys cycle after the 16th rise_tick.
- dato_adc holds its value between strobes.
- Throughput with start held high: one frame per (16+QUIET_CYCLES+1) Clock_Muestreo periods. The +1 is the IDLE fall-tick alignment.
- start deasserted mid-frame does not abort the frame.
- start is assumed synchronous to Clock_Nexys; no internal synchronizer.

Optional Feature:
Macro ADC_ZERO_CHECK_EN.
- Defined: in LOAD, error_cero <= |sr[15:DATA_W]. The flag is sticky until the next LOAD, which recomputes it.
- Undefined: error_cero is tied to 0 and the check logic is absent.
- Either way, dato_adc and dato_valido are unaffected.

Decomposition:
- Shared package servo_pkg: FSM state encoding (IDLE, SHIFT, LOAD, HOLD, QUIET) and constant FRAME_BITS = LEAD_BITS+DATA_W = 16.
- One sub-module, sclk_divider: generates Clock_Muestreo, rise_tick and fall_tick.
- Shift register and FSM stay in adc_serial_rx.

Test Plan:
1. Divider: CLK_DIV=2, start=0 -> Clock_Muestreo period exactly 4 Clock_Nexys cycles, 50% duty; CS stays 1 for 100 periods; dato_valido never asserts.
2. Single frame: start=1 for one Clock_Muestreo period; bench drives 0000 then 0xA5C MSB first on Clock_Muestreo falling edges -> dato_adc=0xA5C, data_basura=0, one dato_valido pulse. CS is low for exactly 16 Clock_Muestreo periods plus the HOLD interval up to the following fall_tick.
3. Back-to-back: start held high, samples 0x000, 0xFFF, 0x801 -> three strobes with matching dato_adc. Strobe spacing = (16+18+1)*4 = 140 Clock_Nexys cycles.
4. Reset mid-frame: assert Reset after 7 rise_ticks -> CS=1 and Clock_Muestreo=0 immediately; dato_valido stays 0; dato_adc=0. A new frame after release receives 0x123 correctly.
5. Start in QUIET: pulse start 5 periods after CS rises, then release -> no new frame; FSM returns to IDLE with CS=1.
6. ADC_ZERO_CHECK_EN: leading bits 0100 with data 0x3C3 -> dato_adc=0x3C3, data_basura=0x4, error_cero=1. A following clean frame clears it to 0. Without the macro, error_cero=0.
